fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Front-end fetch stage. Owns the PC, reads instruction memory, predecodes branches/JAL,
//  queries the 2-bit PHT predictor and steers next PC. Buffers fetched packets in a small FIFO
//  toward decode. Muxes the shared predictor index port between fetch lookups and execute-stage
//  resolution updates, and handles mispredict redirects.
// PARAMETERS
//  RESET_PC  0  instruction index loaded into PC on reset (INSTR_MEM_IDX_W bits)
//  FQ_DEPTH  4  fetch-queue entries; must be a power of 2, >=2
// PORTS
//  clk               in   1                single clock, rising edge
//  rst               in   1                asynchronous, active-high reset
//  imem_addr         out  INSTR_MEM_IDX_W  instruction index; combinational-read memory
//  imem_rdata        in   INSTR_W          instruction at imem_addr, same cycle
//  bp_pc             out  INSTR_MEM_IDX_W  index to predictor (fetch_pc)
//  bp_update_valid   out  1                predictor update enable
//  bp_actual_taken   out  1                resolved direction to predictor
//  bp_pred_taken     in   1                predictor output for bp_pc
//  ex_br_valid       in   1                execute resolved a conditional branch this cycle
//  ex_br_pc          in   INSTR_MEM_IDX_W  index of the resolved branch
//  ex_br_taken       in   1                resolved direction
//  ex_redirect       in   1                mispredict: flush and restart
//  ex_redirect_pc    in   INSTR_MEM_IDX_W  restart index
//  dec_valid         out  1                fetch-queue head valid
//  dec_ready         in   1                decode accepts head
//  dec_pkt           out  $bits(fetch_pkt_t)  head packet {pc, instr, is_br, pred_taken}
// BEHAVIOUR
//  Reset: pc=RESET_PC; queue empty (head=tail=count=0); dec_valid=0; bp_update_valid=0.
//  Predecode (combinational on imem_rdata): is_br = opcode 7'b1100011; is_jal = 7'b1101111.
//   Target = pc + (sign-extended B/J immediate >>> 2), truncated mod 2^INSTR_MEM_IDX_W.
//  Predictor port mux: ex_br_valid=1 -> bp_pc=ex_br_pc, bp_update_valid=1,
//   bp_actual_taken=ex_br_taken, and no fetch this cycle (update-cycle stall).
//   Else bp_pc=pc, bp_update_valid=0, bp_actual_taken=0.
//  fetch_en = !ex_redirect && !ex_br_valid && (count < FQ_DEPTH).
//   Full is checked before dequeue: no enqueue into a full queue even if dec_ready=1.
//  On fetch_en: enqueue {pc, imem_rdata, is_br, is_br & bp_pred_taken}.
//   Next pc: is_jal -> target; is_br & bp_pred_taken -> target; otherwise pc+1 (wraps).
//   pred_taken is forced to 0 for non-branches; JAL is always redirected and never sent to the PHT.
//  Dequeue when dec_valid && dec_ready; enqueue and dequeue may occur in the same cycle (count unchanged).
//  Redirect (highest priority): pc <= ex_redirect_pc; queue flushed (count=0, head=tail=0).
//   Any same-cycle enqueue or dequeue is void. dec_valid=0 the next cycle.
//  Redirect with ex_br_valid in the same cycle: the PHT update still issues; redirect applies too.
//  Without ex_br_valid or ex_redirect, pc holds while full; a held pc re-presents the same lookup.
//  Latency: redirect at cycle N -> new pc's packet visible on dec_pkt at N+2.
//  Reset mid-operation: immediate return to reset state; in-flight packets are lost.
// STRUCTURE
//  general_defines: add INSTR_W=32, OPC_BRANCH, OPC_JAL, FQ_IDX_W, and
//   typedef struct packed fetch_pkt_t {pc, instr, is_br, pred_taken}.
//  Sub-module: fetch_queue (FQ_DEPTH-entry circular FIFO with flush, valid/ready out).
//  Predecode and next-PC logic stay inline in fetch_stage.
// TESTING
//  Reset, RESET_PC=0, imem all NOPs, dec_ready=1 -> packets pc 0,1,2,... one per cycle.
//  dec_ready=0 for 6 cycles -> exactly 4 enqueued; pc frozen at 4; resume -> 0..3 then 4 in order.
//  BEQ at pc 5 imm=+16, bp_pred_taken=1 -> next fetched pc 9; with pred=0 -> pc 6; pkt.pred_taken matches.
//  JAL at pc 3 imm=-12 -> next pc 0; pkt.is_br=0, pred_taken=0.
//  ex_br_valid with ex_br_pc=7, taken=1 -> bp_pc=7, bp_update_valid=1; no enqueue that cycle; pc unchanged.
//  ex_redirect=1, redirect_pc=20 with queue holding 3 entries and dec_ready=1 ->
//   dec_valid=0 next cycle; pkt pc=20 on the following cycle.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: widths, opcodes, the fetch packet layout
// and the next-PC source selector.
package fetch_stage_pkg;

   localparam int unsigned INSTR_MEM_IDX_W = 8;
   localparam int unsigned INSTR_W         = 32;
   localparam int unsigned FQ_IDX_W        = 2;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   typedef struct packed {
      logic [INSTR_MEM_IDX_W-1:0] pc;
      logic [INSTR_W-1:0]         instr;
      logic                       is_br;
      logic                       pred_taken;
   } fetch_pkt_t;

   localparam int unsigned FETCH_PKT_W = $bits(fetch_pkt_t);

   typedef enum logic [1:0] {
      NPC_HOLD,
      NPC_SEQ,
      NPC_TARGET,
      NPC_REDIRECT
   } npc_sel_e;

   // Byte immediate to instruction-index offset, wrapping to the index width.
   function automatic logic [INSTR_MEM_IDX_W-1:0] imm_to_idx_off(input logic signed [31:0] imm);
      return INSTR_MEM_IDX_W'(imm >>> 2);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO between fetch and decode with synchronous flush.
// A push into a full queue is dropped, regardless of a same-cycle pop.
module fetch_queue #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_flush,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_pop_ready,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic              o_full
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [IDX_W-1:0]  r_head;
   logic [IDX_W-1:0]  r_tail;
   logic [IDX_W:0]    r_count;

   logic w_push;
   logic w_pop;

   assign o_full  = (r_count == (IDX_W+1)'(DEPTH));
   assign o_valid = (r_count != '0);
   assign o_data  = r_mem[r_head];

   assign w_push = i_push && !o_full;
   assign w_pop  = o_valid && i_pop_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + 1'b1;
         if (w_pop)  r_head <= r_head + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !i_flush) r_mem[r_tail] <= i_data;
   end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC ownership, branch/JAL predecode, predictor port sharing
// with execute-stage updates, redirect handling and the decode-side queue.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [INSTR_MEM_IDX_W-1:0] RESET_PC = '0,
   parameter int unsigned                FQ_DEPTH = 1 << FQ_IDX_W
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic [INSTR_MEM_IDX_W-1:0] imem_addr,
   input  logic [INSTR_W-1:0]         imem_rdata,
   output logic [INSTR_MEM_IDX_W-1:0] bp_pc,
   output logic                       bp_update_valid,
   output logic                       bp_actual_taken,
   input  logic                       bp_pred_taken,
   input  logic                       ex_br_valid,
   input  logic [INSTR_MEM_IDX_W-1:0] ex_br_pc,
   input  logic                       ex_br_taken,
   input  logic                       ex_redirect,
   input  logic [INSTR_MEM_IDX_W-1:0] ex_redirect_pc,
   output logic                       dec_valid,
   input  logic                       dec_ready,
   output logic [FETCH_PKT_W-1:0]     dec_pkt
);

   logic [INSTR_MEM_IDX_W-1:0] r_pc;

   logic                       w_is_br;
   logic                       w_is_jal;
   logic signed [31:0]         w_b_imm;
   logic signed [31:0]         w_j_imm;
   logic [INSTR_MEM_IDX_W-1:0] w_target;
   logic                       w_fq_full;
   logic                       w_fetch_en;
   npc_sel_e                   w_npc_sel;
   fetch_pkt_t                 w_enq_pkt;

   assign imem_addr = r_pc;

   assign w_is_br  = (imem_rdata[6:0] == OPC_BRANCH);
   assign w_is_jal = (imem_rdata[6:0] == OPC_JAL);
   assign w_b_imm  = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                      imem_rdata[30:25], imem_rdata[11:8], 1'b0};
   assign w_j_imm  = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                      imem_rdata[20], imem_rdata[30:21], 1'b0};
   assign w_target = r_pc + imm_to_idx_off(w_is_jal ? w_j_imm : w_b_imm);

   // Execute-stage updates own the shared predictor port and stall fetch.
   assign bp_pc           = ex_br_valid ? ex_br_pc : r_pc;
   assign bp_update_valid = ex_br_valid;
   assign bp_actual_taken = ex_br_valid & ex_br_taken;

   assign w_fetch_en = !ex_redirect && !ex_br_valid && !w_fq_full;

   assign w_enq_pkt = '{pc:         r_pc,
                        instr:      imem_rdata,
                        is_br:      w_is_br,
                        pred_taken: w_is_br & bp_pred_taken};

   always_comb begin
      w_npc_sel = NPC_HOLD;
      if (ex_redirect) begin
         w_npc_sel = NPC_REDIRECT;
      end else if (w_fetch_en) begin
         if (w_is_jal || (w_is_br && bp_pred_taken)) w_npc_sel = NPC_TARGET;
         else                                       w_npc_sel = NPC_SEQ;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc <= RESET_PC;
      end else begin
         case (w_npc_sel)
            NPC_REDIRECT: r_pc <= ex_redirect_pc;
            NPC_TARGET:   r_pc <= w_target;
            NPC_SEQ:      r_pc <= r_pc + INSTR_MEM_IDX_W'(1);
            default:      r_pc <= r_pc;
         endcase
      end
   end

   fetch_queue #(
      .DEPTH  (FQ_DEPTH),
      .DATA_W (FETCH_PKT_W)
   ) u_fetch_queue (
      .clk         (clk),
      .rst         (rst),
      .i_flush     (ex_redirect),
      .i_push      (w_fetch_en),
      .i_data      (w_enq_pkt),
      .i_pop_ready (dec_ready),
      .o_valid     (dec_valid),
      .o_data      (dec_pkt),
      .o_full      (w_fq_full)
   );

endmodule
